// File: rtl/av2_coeff_decoder.sv
// Coefficient decoder: converts an EOB symbol and signed level symbols into a full raster block
// of dequantized coefficients (zeros included), followed by a single per-block summary handshake.
module av2_coeff_decoder #(
    parameter int MAX_COEFFS = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] context_idx,
    input  logic [15:0] context_prob,
    input  logic [15:0] decoded_symbol,
    input  logic        symbol_valid,
    output logic        symbol_ready,
    output logic [15:0] coeff_out,
    output logic [11:0] coeff_addr,
    output logic        coeff_valid,
    input  logic        coeff_ready,
    output logic [15:0] num_coeffs,
    output logic        coeffs_valid,
    input  logic        coeffs_ready,
    input  logic [5:0]  tx_size,
    input  logic [3:0]  tx_type,
    input  logic [7:0]  qindex,
    input  logic        start,
    output logic        done
);
    localparam int PW = 13;

    typedef enum logic [2:0] {
        S_IDLE, S_GET_EOB, S_NEXT, S_GET_LEVEL, S_EMIT, S_SUMMARY, S_DONE, S_RELEASE
    } state_t;

    state_t          state;
    logic [PW-1:0]   n_q, eob_q, pos_q;
    logic [8:0]      qstep_q;
    logic [PW-1:0]   n_req, n_cap, eob_sel;
    logic signed [24:0] prod;
    logic [15:0]     sat_val;
    logic            symbol_xfer;

    // Context and transform type do not affect a raster-scan decode.
    logic unused_inputs;
    assign unused_inputs = ^{context_idx, context_prob, tx_type};

    assign n_req       = PW'({7'd0, tx_size} * {7'd0, tx_size});
    assign n_cap       = (n_req > PW'(MAX_COEFFS)) ? PW'(MAX_COEFFS) : n_req;
    assign eob_sel     = (decoded_symbol > {3'd0, n_q}) ? n_q : decoded_symbol[PW-1:0];
    assign symbol_xfer = symbol_valid & symbol_ready;

    // qstep is always positive, so it enters the multiply zero-extended.
    assign prod = $signed(decoded_symbol) * $signed({1'b0, qstep_q});

    always_comb begin
        sat_val = prod[15:0];
        if (prod > 25'sd32767)
            sat_val = 16'h7fff;
        else if (prod < -25'sd32768)
            sat_val = 16'h8000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            n_q          <= '0;
            eob_q        <= '0;
            pos_q        <= '0;
            qstep_q      <= '0;
            symbol_ready <= 1'b0;
            coeff_out    <= '0;
            coeff_addr   <= '0;
            coeff_valid  <= 1'b0;
            num_coeffs   <= '0;
            coeffs_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    n_q     <= n_cap;
                    qstep_q <= {1'b0, qindex} + 9'd4;
                    pos_q   <= '0;
                    eob_q   <= '0;
                    if (n_cap == '0) begin
                        coeffs_valid <= 1'b1;
                        num_coeffs   <= '0;
                        state        <= S_SUMMARY;
                    end else begin
                        symbol_ready <= 1'b1;
                        state        <= S_GET_EOB;
                    end
                end
                S_GET_EOB: if (symbol_xfer) begin
                    eob_q        <= eob_sel;
                    symbol_ready <= 1'b0;
                    state        <= S_NEXT;
                end
                S_NEXT: begin
                    if (pos_q < eob_q) begin
                        symbol_ready <= 1'b1;
                        state        <= S_GET_LEVEL;
                    end else if (pos_q < n_q) begin
                        coeff_out   <= '0;
                        coeff_addr  <= pos_q[11:0];
                        coeff_valid <= 1'b1;
                        state       <= S_EMIT;
                    end else begin
                        num_coeffs   <= {3'd0, eob_q};
                        coeffs_valid <= 1'b1;
                        state        <= S_SUMMARY;
                    end
                end
                S_GET_LEVEL: if (symbol_xfer) begin
                    symbol_ready <= 1'b0;
                    coeff_out    <= sat_val;
                    coeff_addr   <= pos_q[11:0];
                    coeff_valid  <= 1'b1;
                    state        <= S_EMIT;
                end
                S_EMIT: if (coeff_ready) begin
                    coeff_valid <= 1'b0;
                    pos_q       <= pos_q + 1'b1;
                    state       <= S_NEXT;
                end
                S_SUMMARY: if (coeffs_ready) begin
                    coeffs_valid <= 1'b0;
                    done         <= 1'b1;
                    state        <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_RELEASE;
                end
                S_RELEASE: if (!start) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_av2_coeff_decoder.sv
// Randomized bench for av2_coeff_decoder against a per-block arithmetic model of the decoded block.
module tb_av2_coeff_decoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] context_idx, context_prob, decoded_symbol;
    logic        symbol_valid, symbol_ready;
    logic [15:0] coeff_out;
    logic [11:0] coeff_addr;
    logic        coeff_valid, coeff_ready;
    logic [15:0] num_coeffs;
    logic        coeffs_valid, coeffs_ready;
    logic [5:0]  tx_size;
    logic [3:0]  tx_type;
    logic [7:0]  qindex;
    logic        start, done;

    av2_coeff_decoder dut (
        .clk(clk), .rst_n(rst_n), .context_idx(context_idx), .context_prob(context_prob),
        .decoded_symbol(decoded_symbol), .symbol_valid(symbol_valid), .symbol_ready(symbol_ready),
        .coeff_out(coeff_out), .coeff_addr(coeff_addr), .coeff_valid(coeff_valid),
        .coeff_ready(coeff_ready), .num_coeffs(num_coeffs), .coeffs_valid(coeffs_valid),
        .coeffs_ready(coeffs_ready), .tx_size(tx_size), .tx_type(tx_type), .qindex(qindex),
        .start(start), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int sym_q[$];
    int got_addr[$];
    int got_data[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Runs one block from sym_q; mode 0 = random ready, 1 = registered ready, 2 = always ready.
    task automatic run_block(input int tx, input int q, input bit hold_start, input int mode);
        int n, eob, exp_v, idx, dones, nsum, num, extra, paddr, pdata;
        bit seen_done, stall, prev_cv;
        got_addr.delete();
        got_data.delete();
        idx = 0; dones = 0; nsum = 0; num = -1; extra = 0;
        seen_done = 0; stall = 0; prev_cv = 0; paddr = 0; pdata = 0;
        @(negedge clk);
        tx_size = 6'(tx); qindex = 8'(q); start = 1'b1;
        for (int cyc = 0; cyc < 30000 && !seen_done; cyc++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            tx_size = 6'($urandom); qindex = 8'($urandom); tx_type = 4'($urandom);
            if (stall) begin
                chk("stall_valid", int'(coeff_valid), 1);
                chk("stall_addr", int'(coeff_addr), paddr);
                chk("stall_data", int'($signed(coeff_out)), pdata);
            end
            case (mode)
                0: coeff_ready = ($urandom_range(0, 3) != 0);
                1: coeff_ready = prev_cv & 1'($urandom_range(0, 1));
                default: coeff_ready = 1'b1;
            endcase
            prev_cv = coeff_valid;
            stall = coeff_valid && !coeff_ready;
            paddr = int'(coeff_addr);
            pdata = int'($signed(coeff_out));
            if (coeff_valid && coeff_ready) begin
                got_addr.push_back(int'(coeff_addr));
                got_data.push_back(int'($signed(coeff_out)));
            end
            coeffs_ready = 1'($urandom_range(0, 1));
            if (coeffs_valid && coeffs_ready) begin
                nsum++;
                num = int'(num_coeffs);
            end
            if (idx < sym_q.size() && $urandom_range(0, 3) != 0) begin
                symbol_valid = 1'b1;
                decoded_symbol = 16'(sym_q[idx]);
            end else begin
                symbol_valid = 1'b0;
                decoded_symbol = 16'($urandom);
            end
            if (symbol_valid && symbol_ready) idx++;
            if (done) begin
                dones++;
                seen_done = 1'b1;
            end
        end
        if (!seen_done) chk("done_timeout", 0, 1);
        symbol_valid = 1'b1;
        coeff_ready = 1'b1;
        coeffs_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (symbol_ready || coeff_valid || coeffs_valid || done) extra++;
        end
        symbol_valid = 1'b0;
        chk("no_retrigger", extra, 0);
        start = 1'b0;

        n = tx * tx;
        eob = (n == 0) ? 0 : ((sym_q[0] > n) ? n : sym_q[0]);
        chk("coeff_count", got_addr.size(), n);
        for (int i = 0; i < n && i < got_addr.size(); i++) begin
            exp_v = (i < eob) ? sat16(sym_q[i + 1] * (q + 4)) : 0;
            chk("coeff_addr", got_addr[i], i);
            chk("coeff_data", got_data[i], exp_v);
        end
        chk("num_coeffs", num, eob);
        chk("summary_count", nsum, 1);
        chk("done_pulses", dones, 1);
        chk("symbols_used", idx, (n == 0) ? 0 : eob + 1);
    endtask

    initial begin
        int tx, q, n, e;
        rst_n = 1'b0; context_idx = '0; context_prob = '0; decoded_symbol = '0;
        symbol_valid = 1'b0; coeff_ready = 1'b0; coeffs_ready = 1'b0;
        tx_size = '0; tx_type = '0; qindex = '0; start = 1'b0;
        #1;
        chk("reset_outs", int'({symbol_ready, coeff_out, coeff_addr, coeff_valid,
                                num_coeffs, coeffs_valid, done}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Small block, three coded levels at qstep 4
        sym_q = '{3, 1, -2, 5, 7, 9};
        run_block(4, 0, 1'b0, 0);
        if (got_data.size() >= 3) begin
            chk("t1_c0", got_data[0], 4);
            chk("t1_c1", got_data[1], -8);
            chk("t1_c2", got_data[2], 20);
        end

        // eob=0 on a 16x16 block: all zeros, one symbol consumed
        sym_q = '{0, 11, 12, 13};
        run_block(16, 37, 1'b0, 2);

        // eob beyond N clipped
        sym_q = '{40};
        for (int i = 0; i < 20; i++) sym_q.push_back(int'($signed(16'($urandom))));
        run_block(4, 9, 1'b0, 0);

        // Saturation at the largest qstep
        sym_q = '{2, 32767, -32768, 100};
        run_block(4, 255, 1'b0, 1);

        // Start held through and beyond done
        sym_q = '{5, 1, 2, 3, 4, 5, 6};
        run_block(3, 17, 1'b1, 1);

        // Zero-size block
        sym_q = '{4, 1};
        run_block(0, 3, 1'b0, 0);

        for (int b = 0; b < 8; b++) begin
            tx = $urandom_range(1, 10);
            q = $urandom_range(0, 255);
            n = tx * tx;
            e = ($urandom_range(0, 4) == 0) ? 65535 : $urandom_range(0, n + 3);
            sym_q = '{e};
            for (int i = 0; i < n + 3; i++) sym_q.push_back(int'($signed(16'($urandom))));
            run_block(tx, q, 1'($urandom_range(0, 1)), b % 3);
        end

        // Reset while a coefficient is stalled
        @(negedge clk);
        tx_size = 6'd8; qindex = 8'd0; start = 1'b1; coeff_ready = 1'b0;
        decoded_symbol = 16'd0; symbol_valid = 1'b1;
        begin
            bit hit = 0;
            for (int cyc = 0; cyc < 50 && !hit; cyc++) begin
                @(negedge clk);
                start = 1'b0;
                if (coeff_valid) hit = 1'b1;
            end
            chk("emit_reached", int'(hit), 1);
        end
        symbol_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midblock_reset", int'({symbol_ready, coeff_out, coeff_addr, coeff_valid,
                                    num_coeffs, coeffs_valid, done}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        coeff_ready = 1'b1;
        begin
            int act = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (symbol_ready || coeff_valid || coeffs_valid || done) act++;
            end
            chk("post_reset_idle", act, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
